// File: rtl/urom_loader.sv
// Boot loader for the writable microcode store: parses A5/N/payload/CHK frames,
// writes 24-bit words to consecutive addresses and releases the core on a verified image.
module urom_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W:0]   words_loaded,
  output logic              done,
  output logic              err,
  output logic              cpu_rstn,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  logic [2:0]      state;
  logic [7:0]      len_q;
  logic [7:0]      acc;
  logic [1:0]      byte_idx;
  logic [15:0]     asm_q;
  logic [ADDR_W:0] target;
  logic            xfer;

  // Handshake: a byte moves only on a cycle where rx_valid && rx_ready; the
  // sender holds rx_data stable until then. rx_ready never depends on rx_valid.
  assign rx_ready  = !rst && (state != S_DONE);
  assign xfer      = rx_valid && rx_ready;
  assign fsm_state = state;

  // A length byte of zero stands for a full store image.
  assign target = (len_q == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len_q        <= 8'd0;
      acc          <= 8'd0;
      byte_idx     <= 2'd0;
      asm_q        <= 16'd0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_rstn     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      // Address and count advance the cycle after each write pulse.
      if (wr_en) begin
        wr_addr      <= wr_addr + 1'b1;
        words_loaded <= words_loaded + 1'b1;
      end
      if (xfer) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) state <= S_LEN;
          end
          S_LEN: begin
            len_q        <= rx_data;
            words_loaded <= '0;
            wr_addr      <= '0;
            acc          <= 8'd0;
            err          <= 1'b0;
            byte_idx     <= 2'd0;
            state        <= S_DATA;
          end
          S_DATA: begin
            acc <= acc + rx_data;
            if (byte_idx == 2'd2) begin
              wr_en    <= 1'b1;
              wr_data  <= {asm_q, rx_data};
              byte_idx <= 2'd0;
              if (words_loaded + 1'b1 == target) state <= S_CHK;
            end else begin
              asm_q    <= {asm_q[7:0], rx_data};
              byte_idx <= byte_idx + 1'b1;
            end
          end
          S_CHK: begin
            if (8'(acc + rx_data) == 8'd0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_rstn <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          S_ERR: begin
            if (rx_data == SYNC_BYTE) state <= S_LEN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_urom_loader.sv
// Directed bench for urom_loader: frames are built from word lists, expected writes
// and status come from the word lists and checksum arithmetic.
module tb_urom_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic [ADDR_W:0]   words_loaded;
  logic              done;
  logic              err;
  logic              cpu_rstn;
  logic [2:0]        fsm_state;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W+23:0] exp_q[$];
  logic [ADDR_W+23:0] cur_e;
  logic               exp_done = 1'b0;
  logic               exp_err  = 1'b0;
  logic               chk_en   = 1'b0;
  logic               prev_wr_en = 1'b0;
  logic [23:0]        words[256];

  always #5 clk = ~clk;

  urom_loader #(.ADDR_W(ADDR_W), .WORD_W(24)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .words_loaded(words_loaded),
    .done(done), .err(err), .cpu_rstn(cpu_rstn), .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle once enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_ready", rx_ready, !rst && !exp_done);
      check("done", done, exp_done);
      check("err", err, exp_err);
      check("cpu_rstn", cpu_rstn, exp_done);
      check("wr_en_known", $isunknown(wr_en), 0);
      if (wr_en === 1'b1) begin
        check("wr_en_back_to_back", prev_wr_en, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", wr_en, 0);
        end else begin
          cur_e = exp_q.pop_front();
          check("wr_addr", wr_addr, cur_e[ADDR_W+23:24]);
          check("wr_data", wr_data, cur_e[23:0]);
        end
      end
      prev_wr_en = wr_en;
    end
  end

  function automatic logic [7:0] calc_chk(input int nwords);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < nwords; i++) s = s + words[i][23:16] + words[i][15:8] + words[i][7:0];
    return 8'(8'd0 - s);
  endfunction

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic took;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    took = rx_ready;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("byte_accepted", took, 1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("pending_writes_at_reset", exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] n_field, input int nwords,
                            input logic [7:0] chk_byte, input int gap_max);
    logic good;
    good = (calc_chk(nwords) == chk_byte);
    send_byte(8'hA5);
    idle($urandom_range(0, gap_max));
    send_byte(n_field);
    exp_err = 1'b0;
    idle($urandom_range(0, gap_max));
    for (int i = 0; i < nwords; i++) begin
      for (int j = 0; j < 3; j++) begin
        send_byte(words[i][23-8*j -: 8]);
        if (j == 2) exp_q.push_back({ADDR_W'(i), words[i]});
        idle($urandom_range(0, gap_max));
      end
    end
    send_byte(chk_byte);
    if (good) exp_done = 1'b1;
    else exp_err = 1'b1;
    idle(2);
    check("writes_drained", exp_q.size(), 0);
    check("words_loaded", words_loaded, nwords);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_words_loaded", words_loaded, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_cpu_rstn", cpu_rstn, 0);

    // Normal load
    words[0] = 24'h123456;
    words[1] = 24'hABCDEF;
    check("chk_model_normal", calc_chk(2), 8'hFD);
    send_frame(8'h02, 2, 8'hFD, 0);
    check("normal_done", done, 1);
    check("normal_err", err, 0);
    check("normal_wr_addr", wr_addr, 2);

    // Backpressure in DONE
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check("bp_done", done, 1);
    check("bp_words_loaded", words_loaded, 2);
    check("bp_wr_addr", wr_addr, 2);

    // Bad checksum, then good resend
    do_reset();
    send_frame(8'h02, 2, 8'h00, 0);
    check("bad_err", err, 1);
    check("bad_done", done, 0);
    check("bad_cpu_rstn", cpu_rstn, 0);
    send_frame(8'h02, 2, 8'hFD, 0);
    check("resend_done", done, 1);
    check("resend_err", err, 0);

    // Junk and gaps
    do_reset();
    send_byte(8'h00);
    idle(3);
    send_byte(8'hFF);
    idle(3);
    send_byte(8'h5A);
    idle(3);
    check("junk_words_loaded", words_loaded, 0);
    send_frame(8'h02, 2, 8'hFD, 3);
    check("junk_done", done, 1);

    // Reset mid-frame
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    check("midrst_cpu_rstn", cpu_rstn, 0);
    check("midrst_words_loaded", words_loaded, 0);
    idle(2);
    words[0] = 24'h334455;
    check("chk_model_single", calc_chk(1), 8'h34);
    send_frame(8'h01, 1, 8'h34, 1);
    check("midrst_done", done, 1);
    check("midrst_wr_addr", wr_addr, 1);

    // Full depth with wrap-around
    do_reset();
    for (int a = 0; a < 256; a++) words[a] = {3{8'(a)}};
    check("chk_model_full", calc_chk(256), 8'h80);
    send_frame(8'h00, 256, 8'h80, 0);
    check("full_words_loaded", words_loaded, 256);
    check("full_wr_addr_wrap", wr_addr, 0);
    check("full_done", done, 1);

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
